sqr_reconstruct_sequential: RTL and testbench
=============================================

// Module: sqr_reconstruct_sequential
// PURPOSE
//  Sequential inverse of the square-root unit: computes sq = root*root + rem.
//  (root, rem) is a square-root result pair; sq reconstructs the original radicand.
//  Uses a shift-add squarer, one partial product per cycle.
//  Used as the datapath partner of the sqrt block and as a round-trip checker in its bench.
// PARAMETERS
//  N  16  radicand width; must be even and >= 4; root is N/2 bits, rem is N/2+1 bits
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      synchronous, active-low reset
//  root       in   N/2    square root operand (unsigned)
//  rem        in   N/2+1  remainder operand (unsigned); legal range 0..2*root
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands
//  sq         out  N      root*root + rem, modulo 2^N
//  rem_err    out  1      rem > 2*root (illegal pair); sq still computed mod 2^N
//  out_valid  out  1      sq/rem_err valid
//  out_ready  in   1      consumer accepts result
// BEHAVIOUR
//  - Reset (reset==0 at a clk edge): state=IDLE, in_ready=1, out_valid=0, sq=0, rem_err=0, counter=0.
//    Reset dominates every other input.
//  - FSM states: IDLE -> CALC -> DONE -> IDLE.
//  - in_ready = (state==IDLE). It is a registered/state decode; no comb path from in_valid.
//  - IDLE: on in_valid&&in_ready, capture the operands:
//    - mcand = root, zero-extended to N bits
//    - mplier = root
//    - acc = rem, zero-extended to N bits
//    - rem_err = (rem > {root,1'b0}), compared at N/2+1 bits
//    - count=0; go to CALC.
//  - CALC, one iteration per cycle:
//    - if mplier[0]: acc <= acc + mcand, truncated to N bits
//    - mcand <= mcand<<1; mplier <= mplier>>1; count <= count+1
//    - after N/2 iterations (count==N/2-1 at the edge), go to DONE and set out_valid=1.
//  - Latency: operands accepted at edge E; out_valid=1 and sq valid after edge E+N/2.
//    No early termination: latency is fixed for all operands.
//  - DONE: sq, rem_err and out_valid are held stable while out_ready==0.
//    On out_valid&&out_ready: out_valid=0, go to IDLE; in_ready=1 the following cycle.
//  - sq and rem_err retain their last value in IDLE; they are only meaningful while out_valid==1.
//  - in_valid outside IDLE is ignored; no operand capture, no queueing.
//  - Width rule: for legal pairs, root^2 + 2*root <= 2^N - 1, so sq never wraps.
//    For illegal pairs, sq wraps mod 2^N and rem_err=1.
//  - Counter width: $clog2(N/2) bits.
//  - Reset mid-CALC or mid-DONE: computation is abandoned; reset values apply on the next cycle.
//  - Throughput: one result per N/2+2 cycles minimum (accept, N/2 CALC cycles, DONE handshake).
// TESTING (N=16)
//  - root=181, rem=95 -> sq=32856, rem_err=0; out_valid exactly 8 cycles after accept.
//  - root=255, rem=510 (max legal pair) -> sq=65535, rem_err=0, no wrap.
//  - root=0, rem=0 -> sq=0; root=0, rem=1 -> sq=1, rem_err=1.
//  - root=3, rem=7 -> sq=16, rem_err=1.
//  - root=255, rem=511 -> sq=0 (wrap), rem_err=1.
//  - out_ready low for 5 cycles in DONE -> sq, rem_err and out_valid stable for all 5 cycles.
//    in_ready stays 0 and a pulsed in_valid is ignored; result accepted on the 6th cycle.
//  - reset=0 asserted during the 4th CALC cycle -> next cycle in_ready=1, out_valid=0, sq=0.
//    A new operation then completes correctly.
//  - Round-trip: random num -> sqrt unit -> this block -> sq==num, rem_err=0.
//    1000 vectors plus num = 0, 1, 65535.

Source files
------------

// File: rtl/sqr_reconstruct_sequential.sv
// Reconstructs a radicand from a square-root pair: sq = root*root + rem (mod 2^N).
// Shift-add squarer retiring one partial product per cycle; fixed N/2-cycle latency.
module sqr_reconstruct_sequential #(
   parameter int unsigned N = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N/2-1:0] root,
   input  logic [N/2:0]   rem,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [N-1:0]   sq,
   output logic           rem_err,
   output logic           out_valid,
   input  logic           out_ready
);

   localparam int unsigned HALF = N / 2;
   localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_in_ready;
   logic            r_out_valid;
   logic [N-1:0]    r_mcand;
   logic [HALF-1:0] r_mplier;
   logic [N-1:0]    r_acc;
   logic [CW-1:0]   r_count;
   logic            r_err;
   logic [N-1:0]    r_sq;
   logic            r_rem_err;
   logic            w_last;
   logic [N-1:0]    w_sum;

   // Partial product for this iteration folded into the accumulator
   assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : N'(0));
   assign w_last = (r_state == S_CALC) && (r_count == CW'(HALF - 1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_next = S_CALC;
         S_CALC:  if (w_last)    w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Handshake flags are registered decodes of the next state
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_in_ready  <= (w_next == S_IDLE);
         r_out_valid <= (w_next == S_DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_count   <= '0;
         r_err     <= 1'b0;
         r_sq      <= '0;
         r_rem_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_mcand  <= N'(root);
                  r_mplier <= root;
                  r_acc    <= N'(rem);
                  r_err    <= (rem > {root, 1'b0});
                  r_count  <= '0;
               end
            end
            S_CALC: begin
               r_acc    <= w_sum;
               r_mcand  <= {r_mcand[N-2:0], 1'b0};
               r_mplier <= {1'b0, r_mplier[HALF-1:1]};
               r_count  <= r_count + CW'(1);
               // Outputs change only at completion so they hold through IDLE and CALC
               if (w_last) begin
                  r_sq      <= w_sum;
                  r_rem_err <= r_err;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign sq        = r_sq;
   assign rem_err   = r_rem_err;

endmodule

// File: tb/tb_sqr_reconstruct_sequential.sv
// Scoreboard bench for sqr_reconstruct_sequential (N=16): directed pairs, stall,
// mid-calculation reset, random pairs and integer-sqrt round trips.
module tb_sqr_reconstruct_sequential;

   localparam int unsigned N = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    root;
   logic [8:0]    rem;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   sq;
   logic          rem_err;
   logic          out_valid;
   logic          out_ready;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic rand_rdy  = 1'b0;
   logic force_rdy = 1'b1;
   logic prev_ov   = 1'b0;

   int exp_sq_q[$];
   int exp_err_q[$];
   int acc_cyc_q[$];

   sqr_reconstruct_sequential #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .root      (root),
      .rem       (rem),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sq        (sq),
      .rem_err   (rem_err),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Consumer readiness: random backpressure or a directed level
   always @(posedge clk) begin
      #2;
      out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int isqrt(input int n);
      int r = 0;
      while ((r + 1) * (r + 1) <= n) r++;
      return r;
   endfunction

   // Monitor: latency at first valid, result held and compared every valid cycle
   always @(negedge clk) begin
      if (reset) begin
         if (out_valid) begin
            check("sb_nonempty", int'(exp_sq_q.size() != 0), 1);
            if (exp_sq_q.size() != 0) begin
               if (!prev_ov) check("latency", cyc - acc_cyc_q[0], 8);
               check("sq", int'(sq), exp_sq_q[0]);
               check("rem_err", int'(rem_err), exp_err_q[0]);
               if (out_ready) begin
                  void'(exp_sq_q.pop_front());
                  void'(exp_err_q.pop_front());
                  void'(acc_cyc_q.pop_front());
               end
            end
         end
         prev_ov = out_valid;
      end else begin
         prev_ov = 1'b0;
      end
   end

   task automatic do_op(input int r, input int m);
      int t = 0;
      @(posedge clk); #1;
      root = 8'(r); rem = 9'(m); in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("accept", int'(in_ready), 1);
      exp_sq_q.push_back((r * r + m) % 65536);
      exp_err_q.push_back(int'(m > 2 * r));
      acc_cyc_q.push_back(cyc + 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_sq_q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("drain", exp_sq_q.size(), 0);
   endtask

   initial begin
      int t;
      reset = 1'b0; in_valid = 1'b0; root = '0; rem = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_sq", int'(sq), 0);
      check("rst_rem_err", int'(rem_err), 0);
      @(posedge clk); #1 reset = 1'b1;

      // Directed pairs from the block description
      do_op(181, 95);
      do_op(255, 510);
      do_op(0, 0);
      do_op(0, 1);
      do_op(3, 7);
      do_op(255, 511);
      drain();

      // Output held under backpressure; pulsed in_valid ignored
      force_rdy = 1'b0;
      do_op(181, 95);
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("stall_valid0", int'(out_valid), 1);
      check("stall_rdy0", int'(in_ready), 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         in_valid = (i == 1);
         root = 8'd3; rem = 9'd7;
         @(negedge clk);
         check("stall_valid", int'(out_valid), 1);
         check("stall_in_ready", int'(in_ready), 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      force_rdy = 1'b1;
      @(negedge clk);
      check("stall_hs_valid", int'(out_valid), 1);
      @(negedge clk);
      check("post_hs_in_ready", int'(in_ready), 1);
      check("post_hs_out_valid", int'(out_valid), 0);
      repeat (12) @(negedge clk);
      check("no_ghost_op", int'(out_valid), 0);

      // Reset during the 4th CALC cycle abandons the operation
      @(posedge clk); #1;
      root = 8'd200; rem = 9'd17; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", int'(in_ready), 1);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_sq", int'(sq), 0);
      do_op(100, 50);
      drain();

      // Random pairs, legal and illegal, with random backpressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 200; i++)
         do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 511)));

      // Round trip through an integer square-root model
      do_op(isqrt(0), 0);
      do_op(isqrt(1), 1 - isqrt(1) * isqrt(1));
      do_op(isqrt(65535), 65535 - isqrt(65535) * isqrt(65535));
      for (int i = 0; i < 1000; i++) begin
         int num, r;
         num = int'($urandom_range(0, 65535));
         r = isqrt(num);
         do_op(r, num - r * r);
         check("rt_model", (r * r + num - r * r) % 65536, num);
      end
      rand_rdy = 1'b0;
      force_rdy = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
